dense_logits_seq: RTL and testbench

Sequential fully-connected layer that produces the logit vector consumed by softmax_fixedpt. It accepts one input vector as a valid/ready element stream and evaluates OUT_SIZE neurons with a single time-multiplexed multiply-accumulate unit. It presents all OUT_SIZE logits in parallel, in signed Q(WIDTH-FRAC).FRAC, held until the consumer accepts them. Weights and biases are loaded through a simple write port.

---
 rtl/dense_logits_seq.sv | 177 +++++++++++++++++
 tb/tb_dense_logits_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_logits_seq.sv
// Sequential dense layer: collects one input vector, evaluates OUT_SIZE neurons with a
// single time-multiplexed MAC, and presents all logits in parallel until accepted.
module dense_logits_seq #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAC      = 8,
  parameter int unsigned IN_SIZE   = 8,
  parameter int unsigned OUT_SIZE  = 4,
  parameter int unsigned ACC_WIDTH = 40
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   w_we,
  input  logic [$clog2(IN_SIZE*OUT_SIZE)-1:0]    w_addr,
  input  logic signed [WIDTH-1:0]                w_data,
  input  logic                                   b_we,
  input  logic [$clog2(OUT_SIZE)-1:0]            b_addr,
  input  logic signed [WIDTH-1:0]                b_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [WIDTH-1:0]                in_data,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [WIDTH-1:0]                out_data [OUT_SIZE],
  output logic                                   out_sat
);

  localparam int unsigned NCoef = IN_SIZE * OUT_SIZE;
  localparam int unsigned WAW   = $clog2(NCoef);
  localparam int unsigned BAW   = $clog2(OUT_SIZE);
  localparam int unsigned IW    = $clog2(IN_SIZE);
  localparam int unsigned OW    = $clog2(OUT_SIZE + 1);

  localparam logic [WAW:0] WLim = (WAW + 1)'(NCoef);
  localparam logic [BAW:0] BLim = (BAW + 1)'(OUT_SIZE);

  localparam logic signed [ACC_WIDTH-1:0] RndC   = ACC_WIDTH'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_WIDTH-1:0] AccMax = {{(ACC_WIDTH-WIDTH+1){1'b0}},
                                                    {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin = {{(ACC_WIDTH-WIDTH+1){1'b1}},
                                                    {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0]     OutMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]     OutMin = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StLoad, StCompute, StOutput} state_e;

  state_e                     r_state, w_state_next;
  logic signed [WIDTH-1:0]    r_x [IN_SIZE];
  logic signed [WIDTH-1:0]    r_w [NCoef];
  logic signed [WIDTH-1:0]    r_b [OUT_SIZE];
  logic [IW-1:0]              r_idx;
  logic [IW-1:0]              r_i;
  logic [OW-1:0]              r_o;
  logic                       r_pend;
  logic [BAW-1:0]             r_pend_o;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [WIDTH-1:0]    r_out [OUT_SIZE];
  logic                       r_sat;

  logic                        w_in_fire, w_close, w_mac_on, w_done, w_last_i;
  logic [BAW-1:0]              w_o_idx;
  logic [WAW-1:0]              w_widx;
  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [ACC_WIDTH-1:0] w_prod_ext, w_bias_ext, w_acc_base, w_acc_next;
  logic signed [ACC_WIDTH-1:0] w_rnd, w_shr;
  logic                        w_pos, w_neg;
  logic signed [WIDTH-1:0]     w_res;

  assign in_ready  = (r_state == StLoad);
  assign out_valid = (r_state == StOutput);
  assign out_sat   = r_sat;
  assign out_data  = r_out;

  assign w_in_fire = in_valid && (r_state == StLoad);
  assign w_close   = w_in_fire && ((r_idx == IW'(IN_SIZE - 1)) || in_last);
  assign w_mac_on  = (r_state == StCompute) && (r_o < OW'(OUT_SIZE));
  // Last neuron's result is still in flight after the final MAC.
  assign w_done    = (r_state == StCompute) && !w_mac_on && r_pend;
  assign w_last_i  = (r_i == IW'(IN_SIZE - 1));

  assign w_o_idx    = r_o[BAW-1:0];
  assign w_widx     = WAW'(32'(r_o) * IN_SIZE + 32'(r_i));
  assign w_prod     = r_w[w_widx] * r_x[r_i];
  assign w_prod_ext = {{(ACC_WIDTH-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_WIDTH-WIDTH){r_b[w_o_idx][WIDTH-1]}}, r_b[w_o_idx]};
  assign w_acc_base = (r_i == '0) ? (w_bias_ext <<< FRAC) : r_acc;
  assign w_acc_next = w_acc_base + w_prod_ext;

  // Round half toward +inf, then clamp into the output range.
  assign w_rnd = r_acc + RndC;
  assign w_shr = w_rnd >>> FRAC;
  assign w_pos = (w_shr > AccMax);
  assign w_neg = (w_shr < AccMin);
  assign w_res = w_pos ? OutMax : (w_neg ? OutMin : w_shr[WIDTH-1:0]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StLoad;
    else     r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StLoad:    if (w_close)   w_state_next = StCompute;
      StCompute: if (w_done)    w_state_next = StOutput;
      StOutput:  if (out_ready) w_state_next = StLoad;
      default:                  w_state_next = StLoad;
    endcase
  end

  // Input capture, MAC sequencing and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(IN_SIZE); k++) r_x[k] <= '0;
      for (int k = 0; k < int'(OUT_SIZE); k++) r_out[k] <= '0;
      r_idx    <= '0;
      r_i      <= '0;
      r_o      <= '0;
      r_pend   <= 1'b0;
      r_pend_o <= '0;
      r_acc    <= '0;
      r_sat    <= 1'b0;
    end else begin
      unique case (r_state)
        StLoad: begin
          if (w_in_fire) begin
            r_x[r_idx] <= in_data;
            r_idx      <= w_close ? '0 : r_idx + 1'b1;
          end
          if (w_close) begin
            r_i    <= '0;
            r_o    <= '0;
            r_pend <= 1'b0;
          end
        end
        StCompute: begin
          if (w_mac_on) begin
            r_acc    <= w_acc_next;
            r_pend   <= w_last_i;
            r_pend_o <= w_o_idx;
            if (w_last_i) begin
              r_i <= '0;
              r_o <= r_o + 1'b1;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_pend <= 1'b0;
          end
          // Retire the previous neuron alongside the next neuron's first MAC.
          if (r_pend) begin
            r_out[r_pend_o] <= w_res;
            if (w_pos || w_neg) r_sat <= 1'b1;
          end
        end
        StOutput: begin
          if (out_ready) begin
            r_sat <= 1'b0;
            for (int k = 0; k < int'(IN_SIZE); k++) r_x[k] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Coefficient storage survives reset; writes are frozen while a vector is computed.
  always_ff @(posedge clk) begin
    if (r_state != StCompute) begin
      if (w_we && ({1'b0, w_addr} < WLim)) r_w[w_addr] <= w_data;
      if (b_we && ({1'b0, b_addr} < BLim)) r_b[b_addr] <= b_data;
    end
  end

endmodule

// File: tb/tb_dense_logits_seq.sv
// Scoreboard bench for dense_logits_seq: stimulus pushes expected logit vectors,
// a monitor pops and compares on every output handshake.
module tb_dense_logits_seq;

  localparam int IN  = 8;
  localparam int OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic w_we = 1'b0;
  logic [4:0] w_addr = '0;
  logic signed [15:0] w_data = '0;
  logic b_we = 1'b0;
  logic [1:0] b_addr = '0;
  logic signed [15:0] b_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [15:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [15:0] out_data [OUT];
  logic out_sat;

  dense_logits_seq dut (
    .clk       (clk),
    .rst       (rst),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT-1:0][15:0] d;
    logic                 sat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic signed [15:0] vec [IN];
  int                 vlen;
  int                 cyc;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare on each accepted output vector.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_vector", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        for (int o = 0; o < OUT; o++)
          check($sformatf("logit%0d", o), int'(out_data[o]), int'($signed(mon_e.d[o])));
        check("out_sat", int'(out_sat), int'(mon_e.sat));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int b, input int c, input int d, input bit s);
    exp_t e;
    e.d[0] = 16'(a);
    e.d[1] = 16'(b);
    e.d[2] = 16'(c);
    e.d[3] = 16'(d);
    e.sat  = s;
    sb_q.push_back(e);
  endtask

  task automatic wr_w(input int a, input int v);
    w_we = 1'b1; w_addr = 5'(a); w_data = 16'(v);
    tick();
    w_we = 1'b0;
  endtask

  task automatic wr_b(input int a, input int v);
    b_we = 1'b1; b_addr = 2'(a); b_data = 16'(v);
    tick();
    b_we = 1'b0;
  endtask

  task automatic fill_w(input int v);
    for (int k = 0; k < IN * OUT; k++) wr_w(k, v);
  endtask

  task automatic fill_b(input int v);
    for (int k = 0; k < OUT; k++) wr_b(k, v);
  endtask

  task automatic set_identity();
    fill_w(0);
    fill_b(0);
    for (int o = 0; o < OUT; o++) wr_w(o * IN + o, 256);
  endtask

  task automatic load_identity_vec();
    vec[0] = 16'sd256; vec[1] = 16'sd512; vec[2] = -16'sd256; vec[3] = 16'sd128;
    for (int k = 4; k < IN; k++) vec[k] = '0;
    vlen = IN;
  endtask

  task automatic send_vec();
    int g;
    for (int k = 0; k < vlen; k++) begin
      g = 0;
      while (!in_ready && g < 200) begin
        tick();
        g++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_data  = vec[k];
      in_last  = (k == vlen - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!out_valid && c < 100) begin
      tick();
      c++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  // Send one vector, check latency and the return to LOAD after the handshake.
  task automatic run_vec(input bit chk_lat);
    int c;
    send_vec();
    check("in_ready_in_compute", int'(in_ready), 0);
    wait_valid(c);
    if (chk_lat) check("latency", c, 33);
    tick();
    check("in_ready_after_accept", int'(in_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sat", int'(out_sat), 0);
    for (int o = 0; o < OUT; o++) check($sformatf("rst_out_data%0d", o), int'(out_data[o]), 0);
    rst = 1'b0;
    tick();

    // Identity
    set_identity();
    load_identity_vec();
    push(256, 512, -256, 128, 0);
    run_vec(1);

    // Bias-only with early last
    fill_w(0);
    wr_b(0, 100); wr_b(1, -100); wr_b(2, 0); wr_b(3, 32767);
    vec[0] = 16'sd5; vec[1] = 16'sd6; vlen = 2;
    push(100, -100, 0, 32767, 0);
    run_vec(1);

    // Rounding with weight 0.5
    fill_b(0);
    wr_w(0, 128);
    vlen = 1;
    vec[0] = 16'sd3;  push(2, 0, 0, 0, 0);  run_vec(1);
    vec[0] = -16'sd3; push(-1, 0, 0, 0, 0); run_vec(1);
    vec[0] = 16'sd1;  push(1, 0, 0, 0, 0);  run_vec(1);

    // Saturation both ways, then a clean vector clears out_sat
    fill_w(32767);
    for (int k = 0; k < IN; k++) vec[k] = 16'sd32767;
    vlen = IN;
    push(32767, 32767, 32767, 32767, 1);
    run_vec(1);
    fill_w(-32768);
    push(-32768, -32768, -32768, -32768, 1);
    run_vec(1);
    set_identity();
    load_identity_vec();
    push(256, 512, -256, 128, 0);
    run_vec(1);

    // Backpressure
    out_ready = 1'b0;
    push(256, 512, -256, 128, 0);
    send_vec();
    wait_valid(cyc);
    for (int t = 0; t < 10; t++) begin
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_logit0", int'(out_data[0]), 256);
      check("bp_logit1", int'(out_data[1]), 512);
      check("bp_logit2", int'(out_data[2]), -256);
      check("bp_logit3", int'(out_data[3]), 128);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_after", int'(in_ready), 1);

    // Coefficient writes during COMPUTE are dropped
    push(256, 512, -256, 128, 0);
    push(256, 512, -256, 128, 0);
    send_vec();
    repeat (5) tick();
    w_we = 1'b1; w_addr = 5'd0; w_data = 16'sd0;
    b_we = 1'b1; b_addr = 2'd0; b_data = 16'sd1000;
    tick();
    w_we = 1'b0; b_we = 1'b0;
    wait_valid(cyc);
    tick();
    check("wg_in_ready_after", int'(in_ready), 1);
    run_vec(1);

    // Reset mid-COMPUTE, coefficients retained
    send_vec();
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("rstmid_out_valid", int'(out_valid), 0);
    check("rstmid_in_ready", int'(in_ready), 1);
    check("rstmid_out_data0", int'(out_data[0]), 0);
    check("rstmid_out_sat", int'(out_sat), 0);
    tick();
    rst = 1'b0;
    tick();
    push(256, 512, -256, 128, 0);
    run_vec(1);

    repeat (3) tick();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
